bus_bridge_hs: RTL and testbench
================================

Name: bus_bridge_hs

Overview:
Parametrised, registered, handshaked bus bridge between the pipeline's MEM stage and data memory plus N memory-mapped peripherals.
- Decodes the peripheral page into N slots and holds each peripheral access until that peripheral acknowledges.
- Data memory is accessed with a fixed latency.
- Accesses to unmapped slots, and peripherals that never acknowledge, complete with an error response instead of hanging the CPU.

Parameters:
N_PERI, 6, number of peripheral slots (1..32)
PERI_PAGE, 20'hFFFFF, addr[31:12] value selecting the peripheral page; any other value selects data memory
SLOT_LSB, 5, slot index = addr[11:SLOT_LSB]; slot size is 2^SLOT_LSB bytes
MEM_LAT, 1, data memory read latency in cycles (>=1)
TIMEOUT, 16, cycles a peripheral may take to ack before error (>=1)

Ports:
clk_from_cpu  in  1  clock, all logic on rising edge
rst_from_cpu  in  1  synchronous active-high reset
req_from_cpu  in  1  access request, held high until ready_to_cpu
we_from_cpu  in  1  1=write, 0=read
addr_from_cpu  in  32  byte address
wdata_from_cpu  in  32  write data
be_from_cpu  in  4  byte enables
rdata_to_cpu  out  32  read data, valid when ready_to_cpu=1
ready_to_cpu  out  1  one-cycle completion pulse
err_to_cpu  out  1  error flag, valid with ready_to_cpu
addr_to_dram  out  32  latched address
we_to_dram  out  1  one-cycle write strobe
wdata_to_dram  out  32  latched write data
be_to_dram  out  4  latched byte enables
rdata_from_dram  in  32  memory read data
sel_to_peri  out  N_PERI  one-hot peripheral select
addr_to_peri  out  32  latched address
we_to_peri  out  1  latched write flag
wdata_to_peri  out  32  latched write data
be_to_peri  out  4  latched byte enables
ack_from_peri  in  N_PERI  per-peripheral acknowledge
rdata_from_peri  in  32*N_PERI  slot k read data at [32k+31:32k]

Behaviour:
- Reset: every output register is 0 and the state is IDLE; this applies at any point, including mid-transaction, and any in-flight write is abandoned.
- FSM states: IDLE, MEM, PERI, RESP.
- IDLE: when req_from_cpu=1 in cycle t, latch addr/we/wdata/be into registers, then decode:
  - addr[31:12]!=PERI_PAGE -> MEM.
  - Slot k<N_PERI -> PERI.
  - Slot k>=N_PERI -> RESP with err=1, rdata=32'hFFFF_FFFF, no strobe issued.
- All bus-side addr/wdata/be outputs are driven from the latched registers and are stable from t+1 until RESP ends.
- MEM:
  - we_to_dram=we for cycle t+1 only.
  - A counter runs MEM_LAT cycles; rdata_from_dram is captured at the end of cycle t+MEM_LAT.
  - ready_to_cpu is high in cycle t+MEM_LAT+1 with err=0.
  - Writes return rdata=0.
- PERI:
  - sel_to_peri[k]=1 and we_to_peri=we, held from t+1 until ack or timeout.
  - An access completes in the cycle where sel[k]&ack_from_peri[k]=1, which is also when the peripheral commits a write.
  - On ack in cycle c: capture rdata_from_peri slice k (0 for writes), sel drops at c+1, ready at c+1, err=0.
  - No ack within cycles t+1..t+TIMEOUT: sel drops, ready at t+TIMEOUT+1, err=1, rdata=32'hFFFF_FFFF.
  - An ack arriving in cycle t+TIMEOUT still counts as success.
- RESP: ready_to_cpu=1 for exactly one cycle, then IDLE.
  - rdata_to_cpu and err_to_cpu hold their values until the next RESP.
  - The CPU may present a new req in the cycle after ready; it is accepted that cycle (one idle cycle between back-to-back accesses).
- Ignored inputs:
  - ack from non-selected slots.
  - ack in IDLE, MEM or RESP.
  - Changes on CPU inputs after acceptance (latched copy is used).
- be is passed through unmodified; be=0 is a legal no-op write.

Test Plan:
- MEM_LAT=1: read 0x0000_0100 with dram data 0xDEADBEEF -> we_to_dram=0, ready at t+2, rdata=0xDEADBEEF, err=0.
- Write 0x0000_0040, wdata 0x12345678, be=4'b0011 -> we_to_dram high only at t+1 with be 0011, ready at t+2, rdata=0.
- Read slot 2 (0xFFFF_F040), ack_from_peri[2] after 3 cycles of sel, data 0x00AA55FF -> sel_to_peri=6'b000100 for cycles t+1..t+3, ready at t+4, rdata=0x00AA55FF.
- Read slot 1 with TIMEOUT=16 and no ack; ack_from_peri[0] pulsed meanwhile -> ignored, ready at t+17, err=1, rdata=0xFFFF_FFFF.
- Access 0xFFFF_F0E0 (slot 7, N_PERI=6) -> no sel or strobe, ready at t+1, err=1.
- Assert reset at t+2 during a peripheral write waiting for ack -> next cycle sel=0, ready=0, state IDLE; a fresh request is then served normally.

Source files
------------

// File: rtl/bus_bridge_hs_if.sv
// bus_bridge_hs_if: CPU, data-memory and peripheral signals of the MEM-stage bus bridge
interface bus_bridge_hs_if #(parameter int N_PERI = 6);
  logic                req_from_cpu;
  logic                we_from_cpu;
  logic [31:0]         addr_from_cpu;
  logic [31:0]         wdata_from_cpu;
  logic [3:0]          be_from_cpu;
  logic [31:0]         rdata_to_cpu;
  logic                ready_to_cpu;
  logic                err_to_cpu;
  logic [31:0]         addr_to_dram;
  logic                we_to_dram;
  logic [31:0]         wdata_to_dram;
  logic [3:0]          be_to_dram;
  logic [31:0]         rdata_from_dram;
  logic [N_PERI-1:0]   sel_to_peri;
  logic [31:0]         addr_to_peri;
  logic                we_to_peri;
  logic [31:0]         wdata_to_peri;
  logic [3:0]          be_to_peri;
  logic [N_PERI-1:0]   ack_from_peri;
  logic [32*N_PERI-1:0] rdata_from_peri;
  modport slave (
    input  req_from_cpu, we_from_cpu, addr_from_cpu, wdata_from_cpu, be_from_cpu,
    input  rdata_from_dram, ack_from_peri, rdata_from_peri,
    output rdata_to_cpu, ready_to_cpu, err_to_cpu,
    output addr_to_dram, we_to_dram, wdata_to_dram, be_to_dram,
    output sel_to_peri, addr_to_peri, we_to_peri, wdata_to_peri, be_to_peri
  );
  modport master (
    output req_from_cpu, we_from_cpu, addr_from_cpu, wdata_from_cpu, be_from_cpu,
    output rdata_from_dram, ack_from_peri, rdata_from_peri,
    input  rdata_to_cpu, ready_to_cpu, err_to_cpu,
    input  addr_to_dram, we_to_dram, wdata_to_dram, be_to_dram,
    input  sel_to_peri, addr_to_peri, we_to_peri, wdata_to_peri, be_to_peri
  );
endinterface

// File: rtl/bus_bridge_hs.sv
// bus_bridge_hs: registered bridge from MEM stage to fixed-latency data memory and N acked peripherals
module bus_bridge_hs #(
  parameter int          N_PERI    = 6,
  parameter logic [19:0] PERI_PAGE = 20'hFFFFF,
  parameter int          SLOT_LSB  = 5,
  parameter int          MEM_LAT   = 1,
  parameter int          TIMEOUT   = 16
) (
  input logic clk_from_cpu,
  input logic rst_from_cpu,
  bus_bridge_hs_if.slave bus
);
  localparam int SW = 12 - SLOT_LSB;
  localparam int CW = $clog2((MEM_LAT > TIMEOUT ? MEM_LAT : TIMEOUT) + 1);
  typedef enum logic [1:0] {IDLE, MEM, PERI, RESP} state_t;
  state_t state, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q, peri_rd;
  logic [3:0]  be_q;
  logic        we_q, err_q, wstb_q;
  logic [CW-1:0] cnt;
  logic [SW-1:0] slot, in_slot;
  logic in_peri, in_map, ack_hit, mem_done, peri_done;
  assign slot      = addr_q[11:SLOT_LSB];
  assign in_slot   = bus.addr_from_cpu[11:SLOT_LSB];
  assign in_peri   = bus.addr_from_cpu[31:12] == PERI_PAGE;
  assign in_map    = int'(in_slot) < N_PERI;
  assign ack_hit   = |(bus.sel_to_peri & bus.ack_from_peri);
  assign mem_done  = state == MEM && cnt == CW'(MEM_LAT - 1);
  assign peri_done = state == PERI && (ack_hit || cnt == CW'(TIMEOUT - 1));
  always_comb begin
    peri_rd = '0;
    for (int k = 0; k < N_PERI; k++)
      if (int'(slot) == k) peri_rd = bus.rdata_from_peri[32*k +: 32];
  end
  always_ff @(posedge clk_from_cpu)
    if (rst_from_cpu) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (bus.req_from_cpu) state_d = !in_peri ? MEM : in_map ? PERI : RESP;
      MEM:  if (mem_done) state_d = RESP;
      PERI: if (peri_done) state_d = RESP;
      RESP: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.ready_to_cpu = state == RESP;
    bus.sel_to_peri  = state == PERI ? N_PERI'(1) << slot : '0;
    bus.we_to_peri   = state == PERI && we_q;
  end
  // Unmapped slots answer straight from IDLE; the ack beats the timeout on the last allowed cycle.
  always_ff @(posedge clk_from_cpu)
    if (rst_from_cpu) begin
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      we_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
      wstb_q <= 1'b0;
      cnt <= '0;
    end else begin
      wstb_q <= 1'b0;
      cnt <= cnt + 1'b1;
      if (state == IDLE && bus.req_from_cpu) begin
        addr_q <= bus.addr_from_cpu;
        wdata_q <= bus.wdata_from_cpu;
        be_q <= bus.be_from_cpu;
        we_q <= bus.we_from_cpu;
        wstb_q <= bus.we_from_cpu && !in_peri;
        cnt <= '0;
        if (in_peri && !in_map) begin
          rdata_q <= '1;
          err_q <= 1'b1;
        end
      end
      if (mem_done) begin
        rdata_q <= we_q ? '0 : bus.rdata_from_dram;
        err_q <= 1'b0;
      end
      if (peri_done) begin
        rdata_q <= !ack_hit ? '1 : we_q ? '0 : peri_rd;
        err_q <= !ack_hit;
      end
    end
  assign bus.rdata_to_cpu  = rdata_q;
  assign bus.err_to_cpu    = err_q;
  assign bus.addr_to_dram  = addr_q;
  assign bus.we_to_dram    = wstb_q;
  assign bus.wdata_to_dram = wdata_q;
  assign bus.be_to_dram    = be_q;
  assign bus.addr_to_peri  = addr_q;
  assign bus.wdata_to_peri = wdata_q;
  assign bus.be_to_peri    = be_q;
endmodule

// File: tb/tb_bus_bridge_hs.sv
// tb_bus_bridge_hs: scoreboard bench for bus_bridge_hs with a delayed-ack peripheral model
module tb_bus_bridge_hs;
  localparam int N = 6;
  localparam int ML = 1;
  localparam int TO = 16;
  typedef struct {int t0; logic [31:0] rdata; logic err; int lat;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_pass = 0;
  int n_chk = 0;
  int sel_cnt = 0;
  int peri_delay = 0;
  logic [31:0] dram_data = '0;
  logic [N-1:0] ack_model = '0;
  logic [N-1:0] ack_extra = '0;
  exp_t sb[$];
  bus_bridge_hs_if #(.N_PERI(N)) bus ();
  bus_bridge_hs #(.N_PERI(N), .MEM_LAT(ML), .TIMEOUT(TO)) dut (
    .clk_from_cpu(clk),
    .rst_from_cpu(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus.rdata_from_dram = dram_data;
  assign bus.ack_from_peri = ack_model | ack_extra;
  for (genvar g = 0; g < N; g++) begin : g_peri
    assign bus.rdata_from_peri[32*g +: 32] = 32'h00AA55FD + 32'(g);
  end
  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
  endtask
  // The peripheral acks in its peri_delay-th selected cycle; 0 means it never acks.
  always @(negedge clk) begin
    sel_cnt = |bus.sel_to_peri ? sel_cnt + 1 : 0;
    ack_model = (peri_delay > 0 && sel_cnt == peri_delay) ? bus.sel_to_peri : '0;
  end
  always @(negedge clk)
    if (!rst && bus.ready_to_cpu) begin
      if (sb.size() == 0) check("unexpected_ready", 96'd1, 96'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("latency", 96'(cyc - e.t0), 96'(e.lat));
        check("rdata", 96'(bus.rdata_to_cpu), 96'(e.rdata));
        check("err", 96'(bus.err_to_cpu), 96'(e.err));
      end
    end
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int delay);
    exp_t e;
    logic peri, mapped;
    int slot;
    logic [N-1:0] exp_sel;
    peri = addr[31:12] == 20'hFFFFF;
    slot = int'(addr[11:5]);
    mapped = slot < N;
    exp_sel = mapped ? N'(1) << slot : '0;
    @(negedge clk);
    peri_delay = delay;
    bus.req_from_cpu = 1'b1;
    bus.we_from_cpu = we;
    bus.addr_from_cpu = addr;
    bus.wdata_from_cpu = wdata;
    bus.be_from_cpu = be;
    e.t0 = cyc;
    if (!peri) begin
      e.lat = ML + 1;
      e.rdata = we ? 32'h0 : dram_data;
      e.err = 1'b0;
    end else if (!mapped) begin
      e.lat = 1;
      e.rdata = 32'hFFFF_FFFF;
      e.err = 1'b1;
    end else if (delay >= 1 && delay <= TO) begin
      e.lat = delay + 1;
      e.rdata = we ? 32'h0 : 32'h00AA55FD + 32'(slot);
      e.err = 1'b0;
    end else begin
      e.lat = TO + 1;
      e.rdata = 32'hFFFF_FFFF;
      e.err = 1'b1;
    end
    sb.push_back(e);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      check("sel", 96'(bus.sel_to_peri), 96'((peri && c < e.lat) ? exp_sel : '0));
      check("we_to_peri", 96'(bus.we_to_peri), 96'(peri && mapped && c < e.lat && we));
      check("we_to_dram", 96'(bus.we_to_dram), 96'(!peri && c == 1 && we));
      check("latched", {bus.addr_to_peri, bus.wdata_to_dram, 28'd0, bus.be_to_dram},
            {addr, wdata, 28'd0, be});
      bus.addr_from_cpu = ~addr;
      bus.wdata_from_cpu = ~wdata;
      bus.be_from_cpu = ~be;
      bus.we_from_cpu = ~we;
      if (bus.ready_to_cpu) break;
      if (c == 40) check("ready_timeout", 96'd0, 96'd1);
    end
    bus.req_from_cpu = 1'b0;
  endtask
  initial begin
    bus.req_from_cpu = 1'b0;
    bus.we_from_cpu = 1'b0;
    bus.addr_from_cpu = '0;
    bus.wdata_from_cpu = '0;
    bus.be_from_cpu = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {bus.rdata_to_cpu, 26'd0, bus.ready_to_cpu, bus.err_to_cpu, bus.we_to_dram,
          bus.sel_to_peri, bus.addr_to_dram}, 96'd0);
    rst = 1'b0;
    dram_data = 32'hDEADBEEF;
    access(1'b0, 32'h0000_0100, 32'h0, 4'hF, 0);
    access(1'b1, 32'h0000_0040, 32'h12345678, 4'b0011, 0);
    access(1'b0, 32'hFFFF_F040, 32'h0, 4'hF, 3);
    fork
      access(1'b0, 32'hFFFF_F020, 32'h0, 4'hF, 0);
      begin
        repeat (4) @(negedge clk);
        ack_extra = 6'b000001;
        repeat (2) @(negedge clk);
        ack_extra = '0;
      end
    join
    access(1'b0, 32'hFFFF_F0E0, 32'h0, 4'hF, 0);
    access(1'b1, 32'hFFFF_F0A0, 32'hCAFE0001, 4'b0000, TO);
    access(1'b1, 32'hFFFF_F000, 32'hCAFE0002, 4'b1100, 1);
    @(negedge clk);
    peri_delay = 0;
    bus.req_from_cpu = 1'b1;
    bus.we_from_cpu = 1'b1;
    bus.addr_from_cpu = 32'hFFFF_F060;
    bus.wdata_from_cpu = 32'h55AA55AA;
    bus.be_from_cpu = 4'hF;
    repeat (2) @(negedge clk);
    check("pre_rst_sel", 96'(bus.sel_to_peri), 96'(6'b001000));
    @(negedge clk);
    rst = 1'b1;
    bus.req_from_cpu = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst", {bus.rdata_to_cpu, 26'd0, bus.ready_to_cpu, bus.err_to_cpu, bus.we_to_peri,
          bus.sel_to_peri}, 96'd0);
    dram_data = 32'h0BADF00D;
    access(1'b0, 32'h0000_2000, 32'h0, 4'hF, 0);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      a = $urandom_range(0, 1) ? {20'hFFFFF, 12'($urandom)} : $urandom & 32'h0FFF_FFFC;
      dram_data = $urandom;
      access(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, TO + 2)));
    end
    repeat (2) @(negedge clk);
    check("sb_empty", 96'(sb.size()), 96'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
